// File: rtl/if_fetch_queue_if.sv
// Fetch-unit bundle: redirect, MMU instruction port and decode-side queue outputs.
// Perf counter outputs exist only when IFQ_PERF_EN is defined.
interface if_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        i_req;
  logic [31:0] i_va;
  logic        i_addr_ok;
  logic        i_double;
  logic        i_tlbr;
  logic        i_pif;
  logic        i_ppi;
  logic        i_data_ok;
  logic [63:0] i_rdata;
  logic        out0_valid;
  logic [31:0] out0_pc;
  logic [31:0] out0_inst;
  logic [2:0]  out0_excp;
  logic        out1_valid;
  logic [31:0] out1_pc;
  logic [31:0] out1_inst;
  logic [2:0]  out1_excp;
  logic [1:0]  out_accept;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_req;
  logic [31:0] perf_stall;
  logic [31:0] perf_drop;

  modport master (
    input  redirect_valid, redirect_pc, i_addr_ok, i_double, i_tlbr, i_pif, i_ppi,
           i_data_ok, i_rdata, out_accept,
    output i_req, i_va, out0_valid, out0_pc, out0_inst, out0_excp,
           out1_valid, out1_pc, out1_inst, out1_excp, perf_req, perf_stall, perf_drop
  );
  modport slave (
    output redirect_valid, redirect_pc, i_addr_ok, i_double, i_tlbr, i_pif, i_ppi,
           i_data_ok, i_rdata, out_accept,
    input  i_req, i_va, out0_valid, out0_pc, out0_inst, out0_excp,
           out1_valid, out1_pc, out1_inst, out1_excp, perf_req, perf_stall, perf_drop
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, i_addr_ok, i_double, i_tlbr, i_pif, i_ppi,
           i_data_ok, i_rdata, out_accept,
    output i_req, i_va, out0_valid, out0_pc, out0_inst, out0_excp,
           out1_valid, out1_pc, out1_inst, out1_excp
  );
  modport slave (
    output redirect_valid, redirect_pc, i_addr_ok, i_double, i_tlbr, i_pif, i_ppi,
           i_data_ok, i_rdata, out_accept,
    input  i_req, i_va, out0_valid, out0_pc, out0_inst, out0_excp,
           out1_valid, out1_pc, out1_inst, out1_excp
  );
`endif
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC, MMU request issue, stale-response discard
// and an in-order instruction queue drained up to two per cycle. IFQ_PERF_EN adds perf counters.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h1c00_0000,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned MAX_OUTST   = 2
) (
  input logic              clk,
  input logic              reset,
  if_fetch_queue_if.master fq
);

  localparam int unsigned QW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = QW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_ADEF = 3'd1;
  localparam logic [2:0] EXC_TLBR = 3'd2;
  localparam logic [2:0] EXC_PIF  = 3'd3;
  localparam logic [2:0] EXC_PPI  = 3'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  excp;
  } entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        dbl;
    logic [2:0]  excp;
  } pend_t;

  entry_t q_mem [QUEUE_DEPTH];
  pend_t  pend_mem [MAX_OUTST];

  logic [31:0]   pc_q, pc_d;
  logic          halted_q, halted_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [QW-1:0] head_q, head_d;
  logic [QW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]    req_excp;
  logic [CW-1:0] free_c;
  logic          issue_c, fire_c, resp_c, adef_c;
  pend_t         pend_hd, pend_new;
  logic [PW-1:0] pw_idx;
  logic          w0_en, w1_en;
  entry_t        w0, w1;
  logic [CW-1:0] push_n;
  logic [QW-1:0] tail1, head1;

  // Fault priority TLBR > PIF > PPI
  always_comb begin
    req_excp = EXC_NONE;
    if (fq.i_tlbr)     req_excp = EXC_TLBR;
    else if (fq.i_pif) req_excp = EXC_PIF;
    else if (fq.i_ppi) req_excp = EXC_PPI;
  end

  // Issue only when every in-flight request is guaranteed two queue slots
  always_comb begin
    free_c  = CW'(QUEUE_DEPTH) - cnt_q;
    issue_c = reset && !halted_q && (pc_q[1:0] == 2'b00)
              && ((32'(outst_q) + 32'(disc_q)) < MAX_OUTST)
              && (32'(free_c) >= 32'(2 * (32'(outst_q) + 32'd1)))
              && !fq.redirect_valid;
    fire_c  = issue_c && fq.i_addr_ok;
    resp_c  = fq.i_data_ok && (disc_q == '0) && !fq.redirect_valid;
    adef_c  = !halted_q && (pc_q[1:0] != 2'b00) && (outst_q == '0)
              && (free_c != '0) && !fq.redirect_valid;
  end

  // Queue write data: response entries or a synthesized ADEF entry
  always_comb begin
    pend_hd       = pend_mem[ph_q];
    pend_new.pc   = pc_q;
    pend_new.dbl  = fq.i_double;
    pend_new.excp = req_excp;
    pw_idx        = PW'((32'(ph_q) + 32'(outst_q)) % MAX_OUTST);
    tail1         = tail_q + QW'(1);
    head1         = head_q + QW'(1);
    w0_en         = resp_c || adef_c;
    w1_en         = resp_c && pend_hd.dbl && (pend_hd.excp == EXC_NONE);
    if (resp_c) begin
      w0.pc   = pend_hd.pc;
      w0.inst = fq.i_rdata[31:0];
      w0.excp = pend_hd.excp;
    end else begin
      w0.pc   = pc_q;
      w0.inst = 32'd0;
      w0.excp = EXC_ADEF;
    end
    w1.pc   = pend_hd.pc + 32'd4;
    w1.inst = fq.i_rdata[63:32];
    w1.excp = EXC_NONE;
    push_n  = CW'(w0_en) + CW'(w1_en);
  end

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    outst_d  = outst_q;
    disc_d   = disc_q;
    ph_d     = ph_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    if (fq.redirect_valid) begin
      // In-flight requests, minus this cycle's response, all become stale
      pc_d     = fq.redirect_pc;
      halted_d = 1'b0;
      outst_d  = '0;
      disc_d   = OW'(32'(disc_q) + 32'(outst_q) - 32'(fq.i_data_ok));
      ph_d     = '0;
      head_d   = '0;
      tail_d   = '0;
      cnt_d    = '0;
    end else begin
      if (fq.i_data_ok) begin
        if (disc_q != '0)                     disc_d = disc_q - OW'(1);
        else if (32'(ph_q) == MAX_OUTST - 1)  ph_d   = '0;
        else                                  ph_d   = ph_q + PW'(1);
      end
      outst_d = OW'(32'(outst_q) + 32'(fire_c) - 32'(resp_c));
      if (fire_c) begin
        pc_d = pc_q + (fq.i_double ? 32'd8 : 32'd4);
        if (req_excp != EXC_NONE) halted_d = 1'b1;
      end
      if (adef_c) halted_d = 1'b1;
      head_d = head_q + QW'(fq.out_accept);
      tail_d = tail_q + QW'(push_n);
      cnt_d  = cnt_q + push_n - CW'(fq.out_accept);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      outst_q  <= '0;
      disc_q   <= '0;
      ph_q     <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      ph_q     <= ph_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage arrays need no reset; validity comes from the counters
  always_ff @(posedge clk) begin
    if (w0_en)  q_mem[tail_q]    <= w0;
    if (w1_en)  q_mem[tail1]     <= w1;
    if (fire_c) pend_mem[pw_idx] <= pend_new;
  end

  assign fq.i_req      = issue_c;
  assign fq.i_va       = pc_q;
  assign fq.out0_valid = (cnt_q != '0);
  assign fq.out0_pc    = q_mem[head_q].pc;
  assign fq.out0_inst  = q_mem[head_q].inst;
  assign fq.out0_excp  = q_mem[head_q].excp;
  assign fq.out1_valid = (cnt_q >= CW'(2));
  assign fq.out1_pc    = q_mem[head1].pc;
  assign fq.out1_inst  = q_mem[head1].inst;
  assign fq.out1_excp  = q_mem[head1].excp;

`ifdef IFQ_PERF_EN
  logic [31:0] perf_req_q, perf_stall_q, perf_drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (fire_c)                    perf_req_q   <= perf_req_q + 32'd1;
      if (issue_c && !fq.i_addr_ok)  perf_stall_q <= perf_stall_q + 32'd1;
      if (fq.i_data_ok && ((disc_q != '0) || fq.redirect_valid))
                                     perf_drop_q  <= perf_drop_q + 32'd1;
    end
  end

  assign fq.perf_req   = perf_req_q;
  assign fq.perf_stall = perf_stall_q;
  assign fq.perf_drop  = perf_drop_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios then random traffic
// against a queue-based transaction model.
module tb_if_fetch_queue;
  localparam int DEPTH = 8;
  localparam int MAXO  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_fetch_queue_if fq();

  if_fetch_queue #(
    .RESET_PC(32'h1c00_0000), .QUEUE_DEPTH(DEPTH), .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .fq(fq)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [2:0] excp; } ent_t;
  typedef struct { logic [31:0] pc; bit dbl; logic [2:0] excp; } req_t;

  ent_t        eq[$];
  req_t        pend[$];
  int          m_disc, mmu_n;
  logic [31:0] m_pc;
  bit          m_halt;
  int          n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req(input bit rv);
    return reset && !m_halt && (m_pc[1:0] == 2'b00) && ((pend.size() + m_disc) < MAXO)
           && ((DEPTH - eq.size()) >= 2 * (pend.size() + 1)) && !rv;
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model at posedge
  task automatic step(input bit rv, input logic [31:0] rpc, input bit aok, input bit dbl,
                      input logic [2:0] flt, input bit dok, input logic [63:0] rd, input int acc);
    bit req, dk;
    int ac, size_pre, npend;
    logic [2:0] ex;
    req_t p;
    ent_t e;
    dk = dok && (mmu_n > 0);
    ac = (acc > eq.size()) ? eq.size() : acc;
    fq.redirect_valid = rv;  fq.redirect_pc = rpc;
    fq.i_addr_ok = aok;      fq.i_double = dbl;
    fq.i_tlbr = flt[2];      fq.i_pif = flt[1];  fq.i_ppi = flt[0];
    fq.i_data_ok = dk;       fq.i_rdata = rd;    fq.out_accept = 2'(ac);
    #1;
    req = exp_req(rv);
    chk("i_req", fq.i_req, req);
    if (req) chk("i_va", fq.i_va, m_pc);
    chk("out0_valid", fq.out0_valid, eq.size() > 0);
    if (eq.size() > 0) begin
      chk("out0_pc", fq.out0_pc, eq[0].pc);
      chk("out0_inst", fq.out0_inst, eq[0].inst);
      chk("out0_excp", fq.out0_excp, eq[0].excp);
    end
    chk("out1_valid", fq.out1_valid, eq.size() > 1);
    if (eq.size() > 1) begin
      chk("out1_pc", fq.out1_pc, eq[1].pc);
      chk("out1_inst", fq.out1_inst, eq[1].inst);
      chk("out1_excp", fq.out1_excp, eq[1].excp);
    end
    ex = flt[2] ? 3'd2 : flt[1] ? 3'd3 : flt[0] ? 3'd4 : 3'd0;
    size_pre = eq.size();
    npend = pend.size();
    @(posedge clk);
    if (dk) mmu_n--;
    if (rv) begin
      m_disc = m_disc + npend - (dk ? 1 : 0);
      pend.delete();
      eq.delete();
      m_pc = rpc;
      m_halt = 0;
    end else begin
      for (int i = 0; i < ac; i++) void'(eq.pop_front());
      if (dk) begin
        if (m_disc > 0) m_disc--;
        else begin
          p = pend.pop_front();
          e.pc = p.pc; e.inst = rd[31:0]; e.excp = p.excp;
          eq.push_back(e);
          if (p.dbl && p.excp == 3'd0) begin
            e.pc = p.pc + 32'd4; e.inst = rd[63:32]; e.excp = 3'd0;
            eq.push_back(e);
          end
        end
      end
      if (req && aok) begin
        p.pc = m_pc; p.dbl = dbl; p.excp = ex;
        pend.push_back(p);
        mmu_n++;
        m_pc = m_pc + (dbl ? 32'd8 : 32'd4);
        if (ex != 3'd0) m_halt = 1;
      end else if (!m_halt && m_pc[1:0] != 2'b00 && (DEPTH - size_pre) > 0) begin
        e.pc = m_pc; e.inst = 32'd0; e.excp = 3'd1;
        eq.push_back(e);
        m_halt = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (6) step(0, 0, 0, 0, 3'b000, 1, {$urandom, $urandom}, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    m_pc = 32'h1c00_0000; m_halt = 0; m_disc = 0; mmu_n = 0;
    reset = 1'b0;
    fq.redirect_valid = 0; fq.redirect_pc = 0; fq.i_addr_ok = 0; fq.i_double = 0;
    fq.i_tlbr = 0; fq.i_pif = 0; fq.i_ppi = 0; fq.i_data_ok = 0; fq.i_rdata = 0;
    fq.out_accept = 0;
    repeat (2) @(negedge clk);
    chk("rst_i_req", fq.i_req, 1'b0);
    chk("rst_out0_valid", fq.out0_valid, 1'b0);
    chk("rst_out1_valid", fq.out1_valid, 1'b0);
    reset = 1'b1;

    // Sequential double fetch
    step(0, 0, 1, 1, 3'b000, 0, 64'd0, 0);
    step(0, 0, 0, 1, 3'b000, 1, {32'h2, 32'h1}, 0);
    chk("seq_out0_pc", fq.out0_pc, 32'h1c00_0000);
    chk("seq_out0_inst", fq.out0_inst, 32'h1);
    chk("seq_out1_pc", fq.out1_pc, 32'h1c00_0004);
    chk("seq_out1_inst", fq.out1_inst, 32'h2);
    chk("seq_next_va", fq.i_va, 32'h1c00_0008);
    drain();

    // Single-instruction fetch
    step(1, 32'h1c00_001c, 0, 0, 3'b000, 0, 64'd0, 0);
    step(0, 0, 1, 0, 3'b000, 0, 64'd0, 0);
    step(0, 0, 0, 0, 3'b000, 1, {32'hdead_beef, 32'h1234_5678}, 0);
    chk("single_out0_pc", fq.out0_pc, 32'h1c00_001c);
    chk("single_out0_inst", fq.out0_inst, 32'h1234_5678);
    chk("single_out1_valid", fq.out1_valid, 1'b0);
    chk("single_next_va", fq.i_va, 32'h1c00_0020);
    drain();

    // Backpressure fills the queue
    repeat (12) step(0, 0, 1, 1, 3'b000, 1, {$urandom, $urandom}, 0);
    chk("bp_i_req", fq.i_req, 1'b0);
    chk("bp_out1_valid", fq.out1_valid, 1'b1);
    drain();

    // Redirect with two outstanding
    step(0, 0, 1, 1, 3'b000, 0, 64'd0, 0);
    step(0, 0, 1, 1, 3'b000, 0, 64'd0, 0);
    step(1, 32'h1c00_0100, 1, 1, 3'b000, 0, 64'd0, 0);
    step(0, 0, 0, 1, 3'b000, 1, {$urandom, $urandom}, 0);
    step(0, 0, 0, 1, 3'b000, 1, {$urandom, $urandom}, 0);
    chk("redir_dropped", fq.out0_valid, 1'b0);
    step(0, 0, 1, 1, 3'b000, 0, 64'd0, 0);
    step(0, 0, 0, 1, 3'b000, 1, {32'h22, 32'h11}, 0);
    chk("redir_out0_pc", fq.out0_pc, 32'h1c00_0100);
    chk("redir_out0_inst", fq.out0_inst, 32'h11);
    drain();

    // TLB refill fault halts fetch
    step(1, 32'h1c00_0040, 0, 0, 3'b000, 0, 64'd0, 0);
    step(0, 0, 1, 1, 3'b100, 0, 64'd0, 0);
    step(0, 0, 1, 1, 3'b000, 1, {32'h99, 32'h77}, 0);
    chk("fault_out0_excp", fq.out0_excp, 3'd2);
    chk("fault_out0_pc", fq.out0_pc, 32'h1c00_0040);
    chk("fault_single", fq.out1_valid, 1'b0);
    repeat (3) step(0, 0, 1, 1, 3'b000, 0, 64'd0, 0);
    chk("fault_i_req", fq.i_req, 1'b0);
    drain();

    // Misaligned redirect raises ADEF
    step(1, 32'h1c00_0102, 0, 0, 3'b000, 0, 64'd0, 0);
    step(0, 0, 1, 1, 3'b000, 0, 64'd0, 0);
    chk("adef_out0_excp", fq.out0_excp, 3'd1);
    chk("adef_out0_inst", fq.out0_inst, 32'd0);
    chk("adef_out0_pc", fq.out0_pc, 32'h1c00_0102);
    chk("adef_i_req", fq.i_req, 1'b0);
    drain();

    // Random traffic
    step(1, 32'h1c00_0200, 0, 0, 3'b000, 0, 64'd0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit          rv;
      logic [31:0] rpc;
      logic [2:0]  flt;
      rv  = ($urandom_range(0, 39) == 0);
      rpc = 32'h1c00_0000 + 32'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 7) == 0) rpc = rpc + 32'd2;
      flt = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(rv, rpc, $urandom_range(0, 9) < 7, 1'($urandom), flt,
           $urandom_range(0, 9) < 6, {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
